// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // FETCH: request in flight, HOLD: response buffered while frozen,
    // DROP: stale request in flight whose response will be thrown away
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        hit;
    } ifid_t;

endpackage

// File: rtl/if_stage_pc_sel.sv
// Redirect-priority mux: interrupt beats mret beats branch; target word aligned.
module pc_sel (
    input  logic        intr_flag_i,
    input  logic [31:0] pc_intr_i,
    input  logic        is_mret_i,
    input  logic [31:0] pc_mret_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        redir_o,
    output logic [31:0] redir_pc_o
);

    logic [31:0] tgt;

    // pick the highest-priority redirect source and clear the low address bits
    always_comb begin
        tgt = br_target_i;
        if (is_mret_i)   tgt = pc_mret_i;
        if (intr_flag_i) tgt = pc_intr_i;
        redir_o    = intr_flag_i | is_mret_i | br_taken_i;
        redir_pc_o = tgt & ~32'd3;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, i-cache request FSM and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        flush_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        intr_flag_i,
    input  logic [31:0] pc_intr_i,
    input  logic        is_mret_i,
    input  logic [31:0] pc_mret_i,
    output logic        imem_valid_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_hit_i,
    output logic [31:0] inst_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc4_d_o,
    output logic        hit_d_o,
    output logic        stall_o
);

    if_state_e   state_q;
    logic [31:0] pc_q, pend_pc_q, buf_inst_q;
    logic        buf_hit_q, kill_q, boot_q;
    ifid_t       ifid_q;

    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] pc4;
    logic        accept, outstanding, have, squash;
    ifid_t       fetched, nop;

    pc_sel u_pc_sel (
        .intr_flag_i (intr_flag_i),
        .pc_intr_i   (pc_intr_i),
        .is_mret_i   (is_mret_i),
        .pc_mret_i   (pc_mret_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .redir_o     (redir),
        .redir_pc_o  (redir_pc)
    );

    // request handshake and what the IF/ID register would take this cycle;
    // boot_q blanks the first cycle after reset so a stale response is ignored
    always_comb begin
        pc4          = pc_q + 32'd4;
        imem_valid_o = !rst_i && !boot_q && (state_q != HOLD);
        imem_addr_o  = pc_q;
        accept       = imem_valid_o && imem_ready_i;
        outstanding  = imem_valid_o && !imem_ready_i;
        stall_o      = outstanding;
        have         = (state_q == FETCH && accept) || (state_q == HOLD);
        squash       = redir || flush_i || kill_q;
        nop          = '{inst: NOP_INST, pc: 32'd0, pc4: 32'd0, hit: 1'b0};
        if (state_q == HOLD)
            fetched = '{inst: buf_inst_q, pc: pc_q, pc4: pc4, hit: buf_hit_q};
        else
            fetched = '{inst: imem_rdata_i, pc: pc_q, pc4: pc4, hit: imem_hit_i};
    end

    // fetch FSM, PC, redirect bookkeeping and IF/ID register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'd0;
            buf_inst_q <= 32'd0;
            buf_hit_q  <= 1'b0;
            kill_q     <= 1'b0;
            boot_q     <= 1'b1;
            ifid_q     <= '{inst: NOP_INST, pc: 32'd0, pc4: 32'd0, hit: 1'b0};
        end else begin
            boot_q <= 1'b0;
            // a squash seen while frozen is remembered until the next enabled edge
            if (enable_i) begin
                ifid_q <= (have && !squash) ? fetched : nop;
                kill_q <= 1'b0;
            end else if (squash) begin
                kill_q <= 1'b1;
            end
            if (redir) begin
                buf_inst_q <= 32'd0;
                buf_hit_q  <= 1'b0;
                if (outstanding) begin
                    pend_pc_q <= redir_pc;
                    state_q   <= DROP;
                end else begin
                    pc_q    <= redir_pc;
                    state_q <= FETCH;
                end
            end else begin
                case (state_q)
                    FETCH: if (accept) begin
                        if (enable_i) begin
                            pc_q <= pc4;
                        end else begin
                            buf_inst_q <= imem_rdata_i;
                            buf_hit_q  <= imem_hit_i;
                            state_q    <= HOLD;
                        end
                    end
                    HOLD: if (enable_i) begin
                        pc_q    <= pc4;
                        state_q <= FETCH;
                    end
                    DROP: if (accept) begin
                        pc_q    <= pend_pc_q;
                        state_q <= FETCH;
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign inst_d_o = ifid_q.inst;
    assign pc_d_o   = ifid_q.pc;
    assign pc4_d_o  = ifid_q.pc4;
    assign hit_d_o  = ifid_q.hit;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming hits, miss, freeze, redirects, wrap, flush.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, enable, flush, br_taken, intr_flag, is_mret;
    logic [31:0] br_target, pc_intr, pc_mret;
    logic        imem_valid, imem_ready, imem_hit, hit_d, stall;
    logic [31:0] imem_addr, imem_rdata, inst_d, pc_d, pc4_d;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    // memory model: word at 8 is a fixed instruction, others encode the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8) return 32'h0050_0093;
        return {a[23:0], 8'h33};
    endfunction

    assign imem_rdata = mem(imem_addr);

    if_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .flush_i      (flush),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .intr_flag_i  (intr_flag),
        .pc_intr_i    (pc_intr),
        .is_mret_i    (is_mret),
        .pc_mret_i    (pc_mret),
        .imem_valid_o (imem_valid),
        .imem_addr_o  (imem_addr),
        .imem_ready_i (imem_ready),
        .imem_rdata_i (imem_rdata),
        .imem_hit_i   (imem_hit),
        .inst_d_o     (inst_d),
        .pc_d_o       (pc_d),
        .pc4_d_o      (pc4_d),
        .hit_d_o      (hit_d),
        .stall_o      (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; land 2ns after the edge so outputs are settled
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; enable = 1; flush = 0; br_taken = 0; intr_flag = 0; is_mret = 0;
        br_target = 0; pc_intr = 0; pc_mret = 0; imem_ready = 0; imem_hit = 0;
        tick();
        chk("rst_valid", {31'd0, imem_valid}, 32'd0);
        chk("rst_inst", inst_d, NOP);
        chk("rst_pc_d", pc_d, 32'd0);
        chk("rst_pc4_d", pc4_d, 32'd0);
        chk("rst_hit_d", {31'd0, hit_d}, 32'd0);

        // streaming hits
        rst = 0; imem_ready = 1; imem_hit = 1; #1;
        chk("boot_valid", {31'd0, imem_valid}, 32'd0);
        tick();
        chk("seq_valid", {31'd0, imem_valid}, 32'd1);
        chk("seq_addr0", imem_addr, 32'h0);
        tick();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_pc_d0", pc_d, 32'h0);
        chk("seq_pc4_d0", pc4_d, 32'h4);
        chk("seq_inst0", inst_d, 32'h0000_0033);
        chk("seq_hit0", {31'd0, hit_d}, 32'd1);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_pc_d4", pc_d, 32'h4);
        chk("seq_pc4_d8", pc4_d, 32'h8);

        // freeze while the hit at 8 returns
        enable = 0; #1;
        chk("frz_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("frz_valid1", {31'd0, imem_valid}, 32'd0);
        chk("frz_pc_d1", pc_d, 32'h4);
        tick();
        chk("frz_valid2", {31'd0, imem_valid}, 32'd0);
        chk("frz_pc_d2", pc_d, 32'h4);
        chk("frz_inst2", inst_d, 32'h0000_0433);
        enable = 1;
        tick();
        chk("thaw_inst", inst_d, 32'h0050_0093);
        chk("thaw_pc_d", pc_d, 32'h8);
        chk("thaw_addr", imem_addr, 32'hC);

        // miss at 0x10 for three cycles
        tick();
        chk("pre_miss_addr", imem_addr, 32'h10);
        imem_ready = 0; #1;
        chk("miss_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("miss_stall2", {31'd0, stall}, 32'd1);
        chk("miss_addr2", imem_addr, 32'h10);
        tick();
        chk("miss_stall3", {31'd0, stall}, 32'd1);
        chk("miss_addr3", imem_addr, 32'h10);
        imem_ready = 1; imem_hit = 0; #1;
        chk("miss_ready_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("miss_inst", inst_d, 32'h0000_1033);
        chk("miss_hit_d", {31'd0, hit_d}, 32'd0);
        chk("miss_pc_d", pc_d, 32'h10);
        chk("miss_next", imem_addr, 32'h14);

        // interrupt beats branch in the same cycle
        imem_hit = 1; br_taken = 1; br_target = 32'h100; intr_flag = 1; pc_intr = 32'h200;
        tick();
        chk("prio_addr", imem_addr, 32'h200);
        chk("prio_inst", inst_d, NOP);
        chk("prio_pc_d", pc_d, 32'h0);
        chk("prio_hit_d", {31'd0, hit_d}, 32'd0);

        // branch during a miss at 0x20: response dropped
        intr_flag = 0; br_target = 32'h20;
        tick();
        chk("drop_setup", imem_addr, 32'h20);
        br_target = 32'h40; imem_ready = 0; #1;
        chk("drop_stall", {31'd0, stall}, 32'd1);
        tick();
        br_taken = 0;
        chk("drop_addr1", imem_addr, 32'h20);
        tick();
        chk("drop_addr2", imem_addr, 32'h20);
        imem_ready = 1;
        tick();
        chk("drop_next", imem_addr, 32'h40);
        chk("drop_inst", inst_d, NOP);
        tick();
        chk("drop_pc_d", pc_d, 32'h40);
        chk("drop_inst40", inst_d, 32'h0000_4033);

        // mret beats branch, low bits cleared, then wrap past the top
        is_mret = 1; pc_mret = 32'hFFFF_FFFE; br_taken = 1; br_target = 32'h80;
        tick();
        chk("mret_addr", imem_addr, 32'hFFFF_FFFC);
        is_mret = 0; br_taken = 0;
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc4_d, 32'h0);

        // flush while frozen kills the next enabled load
        enable = 0; flush = 1;
        tick();
        flush = 0;
        tick();
        chk("kill_valid", {31'd0, imem_valid}, 32'd0);
        chk("kill_hold_pc", pc_d, 32'hFFFF_FFFC);
        enable = 1;
        tick();
        chk("kill_inst", inst_d, NOP);
        chk("kill_addr", imem_addr, 32'h4);
        tick();
        chk("kill_after", inst_d, 32'h0000_0433);
        chk("kill_after_pc", pc_d, 32'h4);

        // reset during a miss; stale ready right after reset is ignored
        imem_ready = 0;
        tick();
        chk("rmiss_stall", {31'd0, stall}, 32'd1);
        rst = 1; #1;
        chk("rmiss_valid", {31'd0, imem_valid}, 32'd0);
        tick();
        rst = 0; imem_ready = 1; #1;
        chk("rmiss_boot", {31'd0, imem_valid}, 32'd0);
        tick();
        chk("rmiss_addr", imem_addr, 32'h0);
        tick();
        chk("rmiss_pc_d", pc_d, 32'h0);
        chk("rmiss_inst", inst_d, 32'h0000_0033);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
